// File: rtl/dlatch_drv_pkg.sv
// Shared types and defaults for the dlatch_drv D-latch driver.
// Optional macro DLATCH_DRV_STAT_EN is consumed by rtl/dlatch_drv.sv.
package dlatch_drv_pkg;

  localparam int unsigned DEB_CNT_DEF  = 4;
  localparam int unsigned EN_WIDTH_DEF = 2;
  localparam logic [7:0]  STAT_MAX     = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLDT  = 3'd4
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, cleared by reset.
module sync2
  import dlatch_drv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dlatch_drv.sv
// Debounces din and drives a downstream D latch with setup/strobe/hold sequencing.
// Define DLATCH_DRV_STAT_EN to add the saturating strobe_cnt output.
module dlatch_drv
  import dlatch_drv_pkg::*;
#(
  parameter int unsigned DEB_CNT  = DEB_CNT_DEF,
  parameter int unsigned EN_WIDTH = EN_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       hold,
  output logic       d_out,
  output logic       en_out,
`ifdef DLATCH_DRV_STAT_EN
  output logic [7:0] strobe_cnt,
`endif
  output logic       busy
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CNT - 1);
  localparam logic [7:0] EN_LAST  = 8'(EN_WIDTH - 1);

  logic       din_s;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cand_q, cand_d;
  logic       dout_q, dout_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (din_s != dout_q && !hold) begin
          cand_d  = din_s;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (din_s != cand_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          dout_d  = cand_q;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == EN_LAST) begin
          cnt_d   = '0;
          state_d = ST_HOLDT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLDT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they align with the state register.
    en_d   = (state_d == ST_STROBE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 1'b0;
      dout_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign d_out  = dout_q;
  assign en_out = en_q;
  assign busy   = busy_q;

`ifdef DLATCH_DRV_STAT_EN
  logic [7:0] stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (state_q != ST_STROBE && state_d == ST_STROBE && stat_q != STAT_MAX) begin
      stat_q <= stat_q + 8'd1;
    end
  end

  assign strobe_cnt = stat_q;
`endif

endmodule

// File: tb/tb_dlatch_drv.sv
// Directed and randomized checks of dlatch_drv against a timestamp-based reference model.
module tb_dlatch_drv;

  localparam int DEB = 4;
  localparam int ENW = 2;

  logic clk = 1'b0;
  logic rst, din, hold;
  logic d_out, en_out, busy;
`ifdef DLATCH_DRV_STAT_EN
  logic [7:0] strobe_cnt;
`endif

  always #5 clk = ~clk;

  dlatch_drv #(.DEB_CNT(DEB), .EN_WIDTH(ENW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .hold       (hold),
    .d_out      (d_out),
    .en_out     (en_out),
`ifdef DLATCH_DRV_STAT_EN
    .strobe_cnt (strobe_cnt),
`endif
    .busy       (busy)
  );

  // Behavioural stand-in for the downstream latch.
  logic udp_q;
  always_latch if (en_out) udp_q = d_out;

  int checks = 0;
  int errors = 0;

  // Reference model: edge index since reset release, din history, capture timestamps.
  bit hist[$];
  int m_t, m_cap, m_settle_from, m_nstrobe;
  bit m_settling, m_cand, m_d;
  bit e_d, e_en, e_busy;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_t = 0; m_cap = -1000; m_settle_from = 0; m_nstrobe = 0;
    m_settling = 0; m_cand = 0; m_d = 0;
    e_d = 0; e_en = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    bit s, idle_before;
    int t;
    t = m_t;
    hist.push_back(din);
    s = (t >= 2) ? hist[t-2] : 1'b0;
    idle_before = !m_settling && !((t-1) >= m_cap && (t-1) <= m_cap + ENW + 1);
    if (m_settling) begin
      if (s != m_cand) m_settling = 0;
      else if (t - m_settle_from == DEB) begin
        m_d = m_cand; m_cap = t; m_settling = 0;
      end
    end else if (idle_before && s != m_d && !hold) begin
      m_settling = 1; m_cand = s; m_settle_from = t;
    end
    if (t == m_cap + 1 && m_nstrobe < 255) m_nstrobe++;
    e_d    = m_d;
    e_en   = (t >= m_cap + 1) && (t <= m_cap + ENW);
    e_busy = m_settling || ((t >= m_cap) && (t <= m_cap + ENW + 1));
    m_t++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) model_reset(); else model_edge();
    check("model_d_out", d_out, e_d);
    check("model_en_out", en_out, e_en);
    check("model_busy", busy, e_busy);
`ifdef DLATCH_DRV_STAT_EN
    check("model_strobe_cnt", strobe_cnt, 8'(m_nstrobe));
`endif
  endtask

  task automatic wait_en(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (en_out === 1'b1) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    rst = 1; din = 0; hold = 0;
    model_reset();
    tick(); tick();
    check("reset_d_out", d_out, 0);
    check("reset_en_out", en_out, 0);
    check("reset_busy", busy, 0);
    rst = 0;

    // Idle after reset with din low
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_en", en_out, 0);
      check("idle_busy", busy, 0);
      check("idle_d", d_out, 0);
    end

    // Glitch: two cycles high then low
    din = 1; tick(); tick(); din = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("glitch_en", en_out, 0);
      check("glitch_d", d_out, 0);
    end
    check("glitch_busy", busy, 0);

    // Hold blocks a new capture, release starts one
    hold = 1; din = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("hold_en", en_out, 0);
      check("hold_busy", busy, 0);
    end
    hold = 0;
    wait_en("hold_release_strobe");
    for (int i = 0; i < 6; i++) tick();
    check("hold_release_d", d_out, 1);

    // Return to 0, then the clean-rise timing from edge k
    din = 0;
    for (int i = 0; i < 16; i++) tick();
    check("fall_d", d_out, 0);
    din = 1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      check("rise_d", d_out, (j >= 6) ? 8'd1 : 8'd0);
      check("rise_en", en_out, (j == 7 || j == 8) ? 8'd1 : 8'd0);
      check("rise_busy", busy, (j >= 2 && j <= 9) ? 8'd1 : 8'd0);
    end

    // Reset in STROBE of a 1->0 capture; latch must hold 0
    din = 0;
    wait_en("fall_strobe");
    rst = 1; tick();
    check("rst_strobe_en", en_out, 0);
    check("rst_strobe_d", d_out, 0);
    check("rst_strobe_udp_q", udp_q, 0);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_en", en_out, 0);
    end

    // Reset in STROBE of a 0->1 capture
    din = 1;
    wait_en("rise_strobe");
    rst = 1; tick();
    check("rst_rise_en", en_out, 0);
    check("rst_rise_d", d_out, 0);
    rst = 0;

    // Randomized din/hold against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) din = ~din;
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      tick();
    end
    hold = 0;

`ifdef DLATCH_DRV_STAT_EN
    rst = 1; tick(); rst = 0;
    check("stat_reset", strobe_cnt, 0);
    for (int n = 0; n < 300; n++) begin
      din = ~din;
      for (int i = 0; i < 14; i++) tick();
      if (n == 2) check("stat_three", strobe_cnt, 3);
    end
    check("stat_saturate", strobe_cnt, 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
